// File: rtl/cv32e40s_xif_result_sequencer.sv
// cv32e40s_xif_result_sequencer
// Records accepted eXtension offloads in program order, absorbs commit/kill
// decisions and out-of-order completions, and returns results strictly in
// issue order. Killed instructions are dropped without producing a result.
// Optional feature macro: CV32E40S_XIF_SEQ_BYPASS_EN. When defined, a head
// completion (exec) or head commit that makes the head presentable drives
// the result channel combinationally in the same cycle; when undefined, all
// result outputs are register-driven with one cycle of latency.
module cv32e40s_xif_result_sequencer #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid_i,
  input  logic                       issue_ready_i,
  output logic                       issue_ready_o,
  input  logic                       issue_accept_i,
  input  logic [X_ID_WIDTH-1:0]      issue_id_i,
  input  logic                       commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]      commit_id_i,
  input  logic                       commit_kill_i,
  input  logic                       exec_valid_i,
  input  logic [X_ID_WIDTH-1:0]      exec_id_i,
  input  logic [X_RFW_WIDTH-1:0]     exec_data_i,
  input  logic [4:0]                 exec_rd_i,
  input  logic                       exec_we_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [X_ID_WIDTH-1:0]      result_id_o,
  output logic [X_RFW_WIDTH-1:0]     result_data_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       proto_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_PEND      = 2'd0,
    ST_COMMITTED = 2'd1,
    ST_KILLED    = 2'd2
  } state_e;

  // Entry storage (data-like; pointers decide which entries are live)
  logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
  logic [X_ID_WIDTH-1:0]  id_d   [DEPTH];
  state_e                 st_q   [DEPTH];
  state_e                 st_d   [DEPTH];
  logic                   done_q [DEPTH];
  logic                   done_d [DEPTH];
  logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
  logic [X_RFW_WIDTH-1:0] data_d [DEPTH];
  logic [4:0]             rd_q   [DEPTH];
  logic [4:0]             rd_d   [DEPTH];
  logic                   we_q   [DEPTH];
  logic                   we_d   [DEPTH];

  // Control state
  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic                   proto_err_q, proto_err_d;
  logic                   res_valid_q, res_valid_d;
  logic [X_ID_WIDTH-1:0]  res_id_q, res_id_d;
  logic [X_RFW_WIDTH-1:0] res_data_q, res_data_d;
  logic [4:0]             res_rd_q, res_rd_d;
  logic                   res_we_q, res_we_d;

  logic [AW-1:0]          head_idx, tail_idx, hidx_d, slot;
  logic [PW-1:0]          count, count_d;
  logic                   full, push, pop;
  logic                   cm_hit, ex_hit, dup_hit, cm_new, ex_new, cm_err;
  logic [AW-1:0]          cm_idx, ex_idx;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign count    = tail_q - head_q;
  assign full     = (head_q[AW] != tail_q[AW]) && (head_idx == tail_idx);

  assign full_o        = full;
  assign count_o       = CW'(count);
  assign proto_err_o   = proto_err_q;
  // While in reset the core sees the decoder's readiness unmodified
  assign issue_ready_o = issue_ready_i & (~full | rst);
  assign push          = issue_valid_i & issue_ready_o & issue_accept_i;

  // Oldest-first CAM over live entries for commit, exec and duplicate-issue ids
  always_comb begin
    cm_hit  = 1'b0;
    cm_idx  = '0;
    ex_hit  = 1'b0;
    ex_idx  = '0;
    dup_hit = 1'b0;
    slot    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_idx + AW'(k);
      if (PW'(k) < count) begin
        if (!cm_hit && (id_q[slot] == commit_id_i)) begin
          cm_hit = 1'b1;
          cm_idx = slot;
        end
        if (!ex_hit && (id_q[slot] == exec_id_i)) begin
          ex_hit = 1'b1;
          ex_idx = slot;
        end
        if (id_q[slot] == issue_id_i) begin
          dup_hit = 1'b1;
        end
      end
    end
  end

`ifdef CV32E40S_XIF_SEQ_BYPASS_EN
  logic byp_exec, byp_commit;

  // Same-cycle presentation when exec or commit completes the head condition
  always_comb begin
    byp_exec   = exec_valid_i & ex_hit & (ex_idx == head_idx) &
                 (st_q[head_idx] == ST_COMMITTED) & ~done_q[head_idx];
    byp_commit = commit_valid_i & ~commit_kill_i & cm_hit & (cm_idx == head_idx) &
                 (st_q[head_idx] == ST_PEND) & done_q[head_idx];
    result_valid_o = res_valid_q | byp_exec | byp_commit;
    result_id_o    = res_id_q;
    result_data_o  = res_data_q;
    result_rd_o    = res_rd_q;
    result_we_o    = res_we_q;
    if (byp_exec) begin
      result_id_o   = id_q[head_idx];
      result_data_o = exec_data_i;
      result_rd_o   = exec_rd_i;
      result_we_o   = exec_we_i;
    end else if (byp_commit) begin
      result_id_o   = id_q[head_idx];
      result_data_o = data_q[head_idx];
      result_rd_o   = rd_q[head_idx];
      result_we_o   = we_q[head_idx];
    end
  end
`else
  assign result_valid_o = res_valid_q;
  assign result_id_o    = res_id_q;
  assign result_data_o  = res_data_q;
  assign result_rd_o    = res_rd_q;
  assign result_we_o    = res_we_q;
`endif

  // Next-state: push, commit/kill, completion, head pop and registered result
  always_comb begin
    id_d   = id_q;
    st_d   = st_q;
    done_d = done_q;
    data_d = data_q;
    rd_d   = rd_q;
    we_d   = we_q;
    cm_err = 1'b0;

    // A commit/exec naming the id being pushed lands on the new entry
    cm_new = push & ~cm_hit & (issue_id_i == commit_id_i);
    ex_new = push & ~ex_hit & (issue_id_i == exec_id_i);

    if (push) begin
      id_d[tail_idx]   = issue_id_i;
      st_d[tail_idx]   = ST_PEND;
      done_d[tail_idx] = 1'b0;
    end

    if (commit_valid_i) begin
      if (cm_hit) begin
        if (st_q[cm_idx] == ST_PEND) begin
          st_d[cm_idx] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
        end else begin
          cm_err = 1'b1;
        end
      end else if (cm_new) begin
        st_d[tail_idx] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
      end else begin
        cm_err = 1'b1;
      end
    end

    // Completions for killed or already-completed entries are dropped, which
    // also keeps a held result stable
    if (exec_valid_i) begin
      if (ex_hit) begin
        if ((st_d[ex_idx] != ST_KILLED) && !done_q[ex_idx]) begin
          done_d[ex_idx] = 1'b1;
          data_d[ex_idx] = exec_data_i;
          rd_d[ex_idx]   = exec_rd_i;
          we_d[ex_idx]   = exec_we_i;
        end
      end else if (ex_new) begin
        if (st_d[tail_idx] != ST_KILLED) begin
          done_d[tail_idx] = 1'b1;
          data_d[tail_idx] = exec_data_i;
          rd_d[tail_idx]   = exec_rd_i;
          we_d[tail_idx]   = exec_we_i;
        end
      end
    end

    pop = (count != '0) &
          ((st_q[head_idx] == ST_KILLED) | (result_valid_o & result_ready_i));

    head_d      = head_q + PW'(pop);
    tail_d      = tail_q + PW'(push);
    count_d     = tail_d - head_d;
    hidx_d      = head_d[AW-1:0];
    proto_err_d = proto_err_q | cm_err | (push & dup_hit);

    res_valid_d = (count_d != '0) && (st_d[hidx_d] == ST_COMMITTED) && done_d[hidx_d];
    res_id_d    = res_valid_d ? id_d[hidx_d]   : '0;
    res_data_d  = res_valid_d ? data_d[hidx_d] : '0;
    res_rd_d    = res_valid_d ? rd_d[hidx_d]   : '0;
    res_we_d    = res_valid_d ? we_d[hidx_d]   : 1'b0;
  end

  // Control and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      proto_err_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_we_q    <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      proto_err_q <= proto_err_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_we_q    <= res_we_d;
    end
  end

  // Entry storage; liveness comes from the pointers so no reset is needed
  always_ff @(posedge clk) begin
    id_q   <= id_d;
    st_q   <= st_d;
    done_q <= done_d;
    data_q <= data_d;
    rd_q   <= rd_d;
    we_q   <= we_d;
  end

endmodule

// File: tb/tb_cv32e40s_xif_result_sequencer.sv
// Testbench for cv32e40s_xif_result_sequencer (default build, no bypass).
// Expected results are queued in issue order; a negedge monitor pops and
// compares every result the core accepts.
module tb_cv32e40s_xif_result_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_i, issue_ready_i, issue_ready_o, issue_accept_i;
  logic [3:0]  issue_id_i;
  logic        commit_valid_i, commit_kill_i;
  logic [3:0]  commit_id_i;
  logic        exec_valid_i, exec_we_i;
  logic [3:0]  exec_id_i;
  logic [31:0] exec_data_i;
  logic [4:0]  exec_rd_i;
  logic        result_valid_o, result_ready_i, result_we_o;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        full_o, proto_err_o;
  logic [2:0]  count_o;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } res_t;

  res_t sb[$];
  res_t mon_got, mon_exp;
  int   n_total = 0;
  int   n_bad   = 0;

  cv32e40s_xif_result_sequencer #(
    .X_ID_WIDTH(4), .X_RFW_WIDTH(32), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_ready_i(issue_ready_i),
    .issue_ready_o(issue_ready_o), .issue_accept_i(issue_accept_i),
    .issue_id_i(issue_id_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i),
    .exec_valid_i(exec_valid_i), .exec_id_i(exec_id_i),
    .exec_data_i(exec_data_i), .exec_rd_i(exec_rd_i), .exec_we_i(exec_we_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .full_o(full_o), .count_o(count_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted result must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && result_valid_o && result_ready_i) begin
      n_total = n_total + 1;
      mon_got = {result_id_o, result_data_o, result_rd_o, result_we_o};
      if (sb.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL sb_unexpected actual id=%0d data=%0h required no result",
                 result_id_o, result_data_o);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          n_bad = n_bad + 1;
          $display("FAIL sb_result actual id=%0d data=%0h rd=%0d we=%0b required id=%0d data=%0h rd=%0d we=%0b",
                   mon_got.id, mon_got.data, mon_got.rd, mon_got.we,
                   mon_exp.id, mon_exp.data, mon_exp.rd, mon_exp.we);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total = n_total + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_issue(input logic [3:0] id);
    issue_valid_i  = 1'b1;
    issue_accept_i = 1'b1;
    issue_id_i     = id;
    tick();
    issue_valid_i  = 1'b0;
    issue_accept_i = 1'b0;
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    tick();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic do_exec(input logic [3:0] id, input logic [31:0] d,
                         input logic [4:0] rd, input logic we);
    exec_valid_i = 1'b1;
    exec_id_i    = id;
    exec_data_i  = d;
    exec_rd_i    = rd;
    exec_we_i    = we;
    tick();
    exec_valid_i = 1'b0;
  endtask

  task automatic sb_push(input logic [3:0] id, input logic [31:0] d,
                         input logic [4:0] rd, input logic we);
    sb.push_back({id, d, rd, we});
  endtask

  initial begin
    rst = 1'b1;
    issue_valid_i = 1'b0; issue_ready_i = 1'b1; issue_accept_i = 1'b0; issue_id_i = '0;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
    exec_valid_i = 1'b0; exec_id_i = '0; exec_data_i = '0; exec_rd_i = '0; exec_we_i = 1'b0;
    result_ready_i = 1'b1;
    tick();
    do_reset();

    // Reset state
    chk("rst_valid", 64'(result_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_err", 64'(proto_err_o), 64'd0);
    chk("rst_rdy", 64'(issue_ready_o), 64'd1);
    chk("rst_fields", 64'({result_id_o, result_data_o, result_rd_o, result_we_o}), 64'd0);

    // In-order return of out-of-order completions
    do_issue(4'd1); do_issue(4'd2); do_issue(4'd3);
    sb_push(4'd1, 32'h1111, 5'd1, 1'b1);
    sb_push(4'd2, 32'h2222, 5'd2, 1'b0);
    sb_push(4'd3, 32'h3333, 5'd3, 1'b1);
    do_commit(4'd1, 1'b0); do_commit(4'd2, 1'b0); do_commit(4'd3, 1'b0);
    chk("t1_count", 64'(count_o), 64'd3);
    do_exec(4'd3, 32'h3333, 5'd3, 1'b1);
    do_exec(4'd2, 32'h2222, 5'd2, 1'b0);
    chk("t1_head_wait", 64'(result_valid_o), 64'd0);
    exec_valid_i = 1'b1; exec_id_i = 4'd1; exec_data_i = 32'h1111;
    exec_rd_i = 5'd1; exec_we_i = 1'b1;
    #1;
    chk("t1_same_cycle", 64'(result_valid_o), 64'd0);
    tick();
    exec_valid_i = 1'b0;
    chk("t1_latency", 64'(result_valid_o), 64'd1);
    chk("t1_first_id", 64'(result_id_o), 64'd1);
    tick();
    chk("t1_second_id", 64'({result_valid_o, result_id_o}), 64'h12);
    tick();
    chk("t1_third_id", 64'({result_valid_o, result_id_o}), 64'h13);
    tick();
    chk("t1_empty", 64'({result_valid_o, count_o}), 64'd0);

    // Kill drops silently
    do_issue(4'd5); do_issue(4'd6);
    do_commit(4'd5, 1'b1);
    do_commit(4'd6, 1'b0);
    do_exec(4'd5, 32'h0055, 5'd5, 1'b1);
    sb_push(4'd6, 32'hDEAD, 5'd7, 1'b1);
    do_exec(4'd6, 32'hDEAD, 5'd7, 1'b1);
    chk("t2_id", 64'({result_valid_o, result_id_o}), 64'h16);
    chk("t2_data", 64'(result_data_o), 64'hDEAD);
    tick(); tick();
    chk("t2_count", 64'(count_o), 64'd0);
    chk("t2_err", 64'(proto_err_o), 64'd0);

    // Full, rejected issues and pointer wrap
    issue_valid_i = 1'b1; issue_accept_i = 1'b0; issue_id_i = 4'd15;
    tick();
    issue_valid_i = 1'b0;
    chk("t3_noaccept", 64'(count_o), 64'd0);
    do_issue(4'd8); do_issue(4'd9); do_issue(4'd10); do_issue(4'd11);
    chk("t3_full", 64'({full_o, count_o}), 64'hC);
    chk("t3_rdy_full", 64'(issue_ready_o), 64'd0);
    do_issue(4'd12);
    chk("t3_full_reject", 64'(count_o), 64'd4);
    for (int r = 0; r < 3; r++) begin
      do_commit(4'(8 + r), 1'b0);
      sb_push(4'(8 + r), 32'hA000 + 32'(r), 5'(r), 1'b1);
      do_exec(4'(8 + r), 32'hA000 + 32'(r), 5'(r), 1'b1);
      // issue in the pop cycle must be refused while still full
      issue_valid_i = 1'b1; issue_accept_i = 1'b1; issue_id_i = 4'(12 + r);
      chk("t3_rdy_popcycle", 64'(issue_ready_o), 64'd0);
      tick();
      issue_valid_i = 1'b0; issue_accept_i = 1'b0;
      chk("t3_after_pop", 64'({full_o, count_o}), 64'd3);
      chk("t3_rdy_open", 64'(issue_ready_o), 64'd1);
      do_issue(4'(12 + r));
      chk("t3_refill", 64'({full_o, count_o}), 64'hC);
    end
    for (int i = 0; i < 4; i++) begin
      do_commit(4'(11 + i), 1'b0);
      sb_push(4'(11 + i), 32'hB000 + 32'(i), 5'(20 + i), 1'(i));
    end
    for (int i = 3; i >= 0; i--) begin
      do_exec(4'(11 + i), 32'hB000 + 32'(i), 5'(20 + i), 1'(i));
    end
    repeat (5) tick();
    chk("t3_drained", 64'(count_o), 64'd0);

    // Backpressure hold
    result_ready_i = 1'b0;
    do_issue(4'd1); do_issue(4'd2);
    do_commit(4'd1, 1'b0); do_commit(4'd2, 1'b0);
    sb_push(4'd1, 32'hA1A1, 5'd9, 1'b1);
    sb_push(4'd2, 32'hA2A2, 5'd10, 1'b0);
    do_exec(4'd1, 32'hA1A1, 5'd9, 1'b1);
    do_exec(4'd2, 32'hA2A2, 5'd10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold", 64'({result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o}),
          64'({1'b1, 4'd1, 32'hA1A1, 5'd9, 1'b1}));
      tick();
    end
    result_ready_i = 1'b1;
    tick();
    chk("t4_next", 64'({result_valid_o, result_id_o, result_data_o}), 64'({1'b1, 4'd2, 32'hA2A2}));
    tick();
    chk("t4_empty", 64'({result_valid_o, count_o}), 64'd0);
    chk("t4_err", 64'(proto_err_o), 64'd0);

    // Double commit: error raised, state unchanged so the result still appears
    do_issue(4'd4);
    do_commit(4'd4, 1'b0);
    chk("t5_err_clean", 64'(proto_err_o), 64'd0);
    do_commit(4'd4, 1'b1);
    chk("t5_err_double", 64'(proto_err_o), 64'd1);
    sb_push(4'd4, 32'h4444, 5'd4, 1'b1);
    do_exec(4'd4, 32'h4444, 5'd4, 1'b1);
    chk("t5_still_committed", 64'({result_valid_o, result_id_o}), 64'h14);
    tick();
    chk("t5_count", 64'(count_o), 64'd0);

    // Commit of an id never issued; sticky flag
    do_reset();
    chk("t5_err_rst", 64'(proto_err_o), 64'd0);
    do_commit(4'd13, 1'b0);
    chk("t5_err_unknown", 64'(proto_err_o), 64'd1);
    repeat (3) tick();
    chk("t5_err_sticky", 64'(proto_err_o), 64'd1);

    // Duplicate live id still pushed, flagged
    do_reset();
    do_issue(4'd7);
    chk("t5_dup_clean", 64'(proto_err_o), 64'd0);
    do_issue(4'd7);
    chk("t5_dup_err", 64'({proto_err_o, count_o}), 64'hA);

    // Reset mid-flight
    do_reset();
    do_issue(4'd1); do_issue(4'd2); do_issue(4'd3); do_issue(4'd9);
    chk("t6_full", 64'(full_o), 64'd1);
    do_commit(4'd1, 1'b0); do_commit(4'd2, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rdy_in_rst", 64'(issue_ready_o), 64'd1);
    tick();
    rst = 1'b0;
    chk("t6_post_rst", 64'({result_valid_o, full_o, proto_err_o, count_o}), 64'd0);
    do_exec(4'd1, 32'hBAD1, 5'd1, 1'b1);
    do_exec(4'd2, 32'hBAD2, 5'd2, 1'b1);
    tick();
    chk("t6_no_stale", 64'({result_valid_o, count_o}), 64'd0);

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
